pwm_reg_bank: RTL and testbench
===============================

Name: pwm_reg_bank

Overview:
- Register bank between the GPMC sync bridge (oe/we/cs/address/data bus) and the pwm core.
- Replaces the flat memory array with:
  - staging registers for period and duty_cycle;
  - an apply/commit mechanism with validation (duty_cycle <= period);
  - optional commit deferral to the PWM period boundary, so the pwm never sees a half-updated 32-bit value;
  - a status register readable over GPMC.

Parameters:
- ADDR_WIDTH, 4, GPMC word address width; registers at 0..5, all other addresses unmapped.
- DATA_WIDTH, 16, bus word width; only 16 supported (32-bit values split HI/LO).
- SYNC_UPDATE, 1, 1 = defer commit to period_end while pwm_en=1; 0 = commit immediately.

Ports:
- clk  input  1  system clock (same clock as gpmc_sync).
- rst_n  input  1  asynchronous active-low reset.
- cs  input  1  chip select from gpmc_sync, active-low.
- we  input  1  write enable from gpmc_sync, active-low.
- oe  input  1  output enable from gpmc_sync, active-low.
- address  input  ADDR_WIDTH  word address.
- data_out  input  DATA_WIDTH  bus write data (host -> FPGA).
- data_in  output  DATA_WIDTH  bus read data (FPGA -> host).
- period_end  input  1  one-cycle pulse in clk domain marking the PWM period boundary.
- pwm_rst  output  1  to pwm rst.
- pwm_en  output  1  to pwm en.
- pwm_polarity  output  1  to pwm polarity.
- period  output  32  active period.
- duty_cycle  output  32  active duty cycle.
- update  output  1  one-cycle pulse on each successful commit.

Behaviour:
- Reset (rst_n=0, async): pwm_rst=1, pwm_en=0, pwm_polarity=0, period=0, duty_cycle=0, data_in=0, update=0; staging registers and STATUS = 0.
- Write access: cs=0, we=0, oe=1.
  - A write is accepted once per access, on the first cycle the condition becomes true (rising edge of a registered write_active flag).
  - Held cycles do not re-trigger.
- Read access: cs=0, we=1, oe=0.
  - data_in is registered with 1-cycle latency.
  - data_in=0 in every cycle without a read.
  - Unmapped addresses read 0; writes to them are ignored.
- Register map:
  - 0 CTRL: bit0 pwm_rst, bit1 pwm_en, bit2 pwm_polarity, bit3 APPLY (write-only, reads 0). Bits 0-2 take effect the cycle after the write.
  - 1 PERIOD_HI, 2 PERIOD_LO, 3 DUTY_HI, 4 DUTY_LO: staging, read/write.
  - 5 STATUS:
    - bit0 PENDING (RO);
    - bit1 REJECT (W1C): apply refused because duty > period;
    - bit2 DROP (W1C): staging write or apply ignored while pending.
- Commit FSM states:
  - IDLE: write with APPLY=1 and staged duty > staged period (unsigned 32-bit compare) -> set REJECT, stay IDLE, outputs unchanged.
  - IDLE: write with APPLY=1 and valid values:
    - if SYNC_UPDATE=0, or pwm_en=0 at the cycle of acceptance -> COMMIT;
    - else -> PENDING.
  - PENDING: wait for period_end. A period_end in the same cycle the apply is accepted does not count. On period_end -> COMMIT.
  - COMMIT (1 cycle): copy staging to period/duty_cycle, pulse update=1 for that cycle, -> IDLE.
- Pending state:
  - PENDING=1 in PENDING and COMMIT.
  - While pending, writes to addresses 1-4 and APPLY are dropped and set DROP.
  - CTRL bits 0-2 in the same write still take effect.
  - If pwm_en is cleared while PENDING, commit on the next cycle without waiting for period_end.
- Apply latency: commit outputs visible 2 cycles after write acceptance when immediate.
- W1C and a set event in the same cycle: set wins.
- Async reset mid-pending: pending commit is discarded; outputs return to reset values.

Test Plan:
- Reset, then read addresses 0..7 -> CTRL reads 0x0001; all others read 0; data_in valid 1 cycle after oe falls.
- Write PERIOD=0x0000_0064, DUTY=0x0000_0032, then CTRL=0x0008 (pwm_en=0) -> update pulses once; period=100, duty_cycle=50; STATUS=0.
- SYNC_UPDATE=1, CTRL=0x0002 active, stage DUTY=0x0000_0010, APPLY -> STATUS.PENDING=1 and outputs unchanged until period_end; then duty_cycle=16, update 1 cycle, PENDING=0.
- Stage DUTY=0x0000_00C8 with period 100, APPLY -> STATUS=0x0002, no update pulse; write STATUS=0x0002 -> reads 0.
- While PENDING, write DUTY_LO=0x0005 -> staging unchanged, STATUS bit2 set; clear pwm_en -> commit next cycle with old staged value.
- Hold a write access for 5 cycles with APPLY -> exactly one update pulse; assert rst_n=0 while PENDING -> no update; outputs at reset values.

Source files
------------

// File: rtl/pwm_reg_bank_if.sv
// GPMC-side bus between gpmc_sync and the PWM register bank.
// All strobes are active-low; data_out flows host->FPGA, data_in FPGA->host.
interface pwm_reg_bank_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
);
    logic                  cs;
    logic                  we;
    logic                  oe;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_out;
    logic [DATA_WIDTH-1:0] data_in;

    modport master (
        output cs, we, oe, address, data_out,
        input  data_in
    );

    modport slave (
        input  cs, we, oe, address, data_out,
        output data_in
    );
endinterface

// File: rtl/pwm_reg_bank.sv
// PWM register bank: staged PERIOD/DUTY, validated apply with optional
// deferral to the PWM period boundary, and a W1C status register.
module pwm_reg_bank #(
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 16,
    parameter bit SYNC_UPDATE = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    pwm_reg_bank_if.slave  bus,
    input  logic           period_end,
    output logic           pwm_rst,
    output logic           pwm_en,
    output logic           pwm_polarity,
    output logic [31:0]    period,
    output logic [31:0]    duty_cycle,
    output logic           update
);

    localparam logic [ADDR_WIDTH-1:0] A_CTRL      = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_PERIOD_HI = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_PERIOD_LO = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_DUTY_HI   = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] A_DUTY_LO   = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS    = ADDR_WIDTH'(5);

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        COMMIT
    } state_t;

    state_t state, state_next;

    logic        write_cond, read_cond, write_active, write_stb;
    logic        wr_ctrl, wr_status, stage_wr, apply_req, pending, duty_ok;
    logic        reject_set, drop_set, reject_flag, drop_flag;
    logic [31:0] period_stage, duty_stage;
    logic [15:0] rd_value;

    assign write_cond = !bus.cs && !bus.we && bus.oe;
    assign read_cond  = !bus.cs && bus.we && !bus.oe;
    // Only the first cycle of a held write access is acted upon.
    assign write_stb  = write_cond && !write_active;

    assign wr_ctrl   = write_stb && (bus.address == A_CTRL);
    assign wr_status = write_stb && (bus.address == A_STATUS);
    assign stage_wr  = write_stb && (bus.address >= A_PERIOD_HI) && (bus.address <= A_DUTY_LO);
    assign apply_req = wr_ctrl && bus.data_out[3];
    assign pending   = (state != IDLE);
    assign duty_ok   = (duty_stage <= period_stage);
    assign drop_set  = pending && (stage_wr || apply_req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        reject_set = 1'b0;
        case (state)
            IDLE: begin
                if (apply_req) begin
                    if (!duty_ok)                   reject_set = 1'b1;
                    else if (!SYNC_UPDATE || !pwm_en) state_next = COMMIT;
                    else                            state_next = PENDING;
                end
            end
            // Losing pwm_en means no period_end is coming, so commit at once.
            PENDING: if (period_end || !pwm_en) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_active <= 1'b0;
            pwm_rst      <= 1'b1;
            pwm_en       <= 1'b0;
            pwm_polarity <= 1'b0;
            period_stage <= '0;
            duty_stage   <= '0;
            period       <= '0;
            duty_cycle   <= '0;
            update       <= 1'b0;
            reject_flag  <= 1'b0;
            drop_flag    <= 1'b0;
        end else begin
            write_active <= write_cond;
            if (wr_ctrl) begin
                pwm_rst      <= bus.data_out[0];
                pwm_en       <= bus.data_out[1];
                pwm_polarity <= bus.data_out[2];
            end
            if (stage_wr && !pending) begin
                case (bus.address)
                    A_PERIOD_HI: period_stage[31:16] <= bus.data_out[15:0];
                    A_PERIOD_LO: period_stage[15:0]  <= bus.data_out[15:0];
                    A_DUTY_HI:   duty_stage[31:16]   <= bus.data_out[15:0];
                    default:     duty_stage[15:0]    <= bus.data_out[15:0];
                endcase
            end
            if (state == COMMIT) begin
                period     <= period_stage;
                duty_cycle <= duty_stage;
            end
            update <= (state == COMMIT);
            // A set event in the same cycle as a W1C clear wins.
            reject_flag <= reject_set || (reject_flag && !(wr_status && bus.data_out[1]));
            drop_flag   <= drop_set   || (drop_flag   && !(wr_status && bus.data_out[2]));
        end
    end

    always_comb begin
        rd_value = '0;
        case (bus.address)
            A_CTRL:      rd_value = {13'd0, pwm_polarity, pwm_en, pwm_rst};
            A_PERIOD_HI: rd_value = period_stage[31:16];
            A_PERIOD_LO: rd_value = period_stage[15:0];
            A_DUTY_HI:   rd_value = duty_stage[31:16];
            A_DUTY_LO:   rd_value = duty_stage[15:0];
            A_STATUS:    rd_value = {13'd0, drop_flag, reject_flag, pending};
            default:     rd_value = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         bus.data_in <= '0;
        else if (read_cond) bus.data_in <= DATA_WIDTH'(rd_value);
        else                bus.data_in <= '0;
    end

endmodule

// File: tb/tb_pwm_reg_bank.sv
// Directed testbench for pwm_reg_bank: register map, apply/commit FSM,
// reject/drop status handling, held writes and reset during a pending commit.
module tb_pwm_reg_bank;

    logic        clk;
    logic        rst_n;
    logic        period_end;
    logic        pwm_rst, pwm_en, pwm_polarity, update;
    logic [31:0] period, duty_cycle;
    logic [15:0] rd;
    int          checks;
    int          errors;
    int          update_count;
    int          base_count;

    pwm_reg_bank_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) bus_if ();

    pwm_reg_bank #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .SYNC_UPDATE(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus_if),
        .period_end   (period_end),
        .pwm_rst      (pwm_rst),
        .pwm_en       (pwm_en),
        .pwm_polarity (pwm_polarity),
        .period       (period),
        .duty_cycle   (duty_cycle),
        .update       (update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count update pulses away from the edge that drives them.
    initial update_count = 0;
    always @(negedge clk) if (update) update_count++;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic busIdle();
        bus_if.cs       = 1'b1;
        bus_if.we       = 1'b1;
        bus_if.oe       = 1'b1;
        bus_if.address  = '0;
        bus_if.data_out = '0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Write access held for 'hold' cycles, optionally with period_end on the accepting edge.
    task automatic applyStimulus(input logic [3:0] addr, input logic [15:0] data,
                                 input int hold, input logic pe);
        bus_if.cs       = 1'b0;
        bus_if.we       = 1'b0;
        bus_if.oe       = 1'b1;
        bus_if.address  = addr;
        bus_if.data_out = data;
        period_end      = pe;
        cycles(1);
        period_end      = 1'b0;
        if (hold > 1) cycles(hold - 1);
        busIdle();
        cycles(1);
    endtask

    task automatic readReg(input logic [3:0] addr, output logic [15:0] value);
        bus_if.cs      = 1'b0;
        bus_if.we      = 1'b1;
        bus_if.oe      = 1'b0;
        bus_if.address = addr;
        cycles(1);
        value = bus_if.data_in;
        busIdle();
    endtask

    initial begin
        logic [15:0] exp_map [8];
        checks     = 0;
        errors     = 0;
        period_end = 1'b0;
        rst_n      = 1'b0;
        busIdle();
        cycles(2);

        checkOutput("reset pwm_rst", 32'(pwm_rst), 32'd1);
        checkOutput("reset pwm_en", 32'(pwm_en), 32'd0);
        checkOutput("reset period", period, 32'd0);
        checkOutput("reset duty", duty_cycle, 32'd0);
        checkOutput("reset update", 32'(update), 32'd0);
        rst_n = 1'b1;
        cycles(1);

        // Register map after reset; read data appears one cycle after oe falls.
        bus_if.cs = 1'b0; bus_if.we = 1'b1; bus_if.oe = 1'b0; bus_if.address = 4'd0;
        #1;
        checkOutput("read latency before edge", 32'(bus_if.data_in), 32'd0);
        busIdle();
        exp_map = '{16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        for (int a = 0; a < 8; a++) begin
            readReg(4'(a), rd);
            checkOutput($sformatf("reset read addr %0d", a), 32'(rd), 32'(exp_map[a]));
        end
        cycles(1);
        checkOutput("data_in idle zero", 32'(bus_if.data_in), 32'd0);

        // Immediate commit with pwm_en=0.
        base_count = update_count;
        applyStimulus(4'd1, 16'h0000, 1, 1'b0);
        applyStimulus(4'd2, 16'h0064, 1, 1'b0);
        applyStimulus(4'd3, 16'h0000, 1, 1'b0);
        applyStimulus(4'd4, 16'h0032, 1, 1'b0);
        readReg(4'd2, rd);
        checkOutput("staged PERIOD_LO", 32'(rd), 32'h64);
        checkOutput("no commit before apply", period, 32'd0);
        applyStimulus(4'd0, 16'h0008, 1, 1'b0);
        checkOutput("immediate update pulse", 32'(update), 32'd1);
        checkOutput("immediate period", period, 32'd100);
        checkOutput("immediate duty", duty_cycle, 32'd50);
        checkOutput("ctrl clears pwm_rst", 32'(pwm_rst), 32'd0);
        cycles(1);
        checkOutput("update one cycle", 32'(update), 32'd0);
        checkOutput("immediate pulse count", 32'(update_count - base_count), 32'd1);
        readReg(4'd5, rd);
        checkOutput("status after commit", 32'(rd), 32'd0);

        // Deferred commit while pwm runs.
        applyStimulus(4'd0, 16'h0002, 1, 1'b0);
        checkOutput("pwm_en set", 32'(pwm_en), 32'd1);
        applyStimulus(4'd4, 16'h0010, 1, 1'b0);
        base_count = update_count;
        applyStimulus(4'd0, 16'h000A, 1, 1'b0);
        readReg(4'd5, rd);
        checkOutput("status pending", 32'(rd), 32'h1);
        cycles(3);
        checkOutput("duty held while pending", duty_cycle, 32'd50);
        checkOutput("no pulse while pending", 32'(update_count - base_count), 32'd0);
        period_end = 1'b1;
        cycles(1);
        period_end = 1'b0;
        checkOutput("no update on period_end edge", 32'(update), 32'd0);
        cycles(1);
        checkOutput("deferred update pulse", 32'(update), 32'd1);
        checkOutput("deferred duty", duty_cycle, 32'd16);
        readReg(4'd5, rd);
        checkOutput("pending cleared", 32'(rd), 32'd0);

        // Rejected apply (duty 200 > period 100), then W1C.
        applyStimulus(4'd4, 16'h00C8, 1, 1'b0);
        base_count = update_count;
        applyStimulus(4'd0, 16'h000A, 1, 1'b0);
        cycles(3);
        readReg(4'd5, rd);
        checkOutput("status reject", 32'(rd), 32'h2);
        checkOutput("reject no pulse", 32'(update_count - base_count), 32'd0);
        checkOutput("reject duty unchanged", duty_cycle, 32'd16);
        applyStimulus(4'd5, 16'h0002, 1, 1'b0);
        readReg(4'd5, rd);
        checkOutput("reject cleared", 32'(rd), 32'd0);

        // period_end alongside the apply is ignored; writes while pending drop.
        applyStimulus(4'd4, 16'h0020, 1, 1'b0);
        applyStimulus(4'd0, 16'h000A, 1, 1'b1);
        readReg(4'd5, rd);
        checkOutput("same-cycle period_end ignored", 32'(rd), 32'h1);
        applyStimulus(4'd4, 16'h0005, 1, 1'b0);
        readReg(4'd4, rd);
        checkOutput("dropped staging write", 32'(rd), 32'h20);
        readReg(4'd5, rd);
        checkOutput("status drop", 32'(rd), 32'h5);
        base_count = update_count;
        applyStimulus(4'd0, 16'h0000, 1, 1'b0);
        checkOutput("pwm_en cleared", 32'(pwm_en), 32'd0);
        cycles(1);
        checkOutput("commit after pwm_en off", 32'(update), 32'd1);
        checkOutput("old staged duty committed", duty_cycle, 32'd32);
        applyStimulus(4'd5, 16'h0004, 1, 1'b0);
        readReg(4'd5, rd);
        checkOutput("drop cleared", 32'(rd), 32'd0);

        // Held write access triggers a single apply.
        applyStimulus(4'd4, 16'h0030, 1, 1'b0);
        base_count = update_count;
        applyStimulus(4'd0, 16'h0008, 5, 1'b0);
        cycles(3);
        checkOutput("held write one pulse", 32'(update_count - base_count), 32'd1);
        checkOutput("held write duty", duty_cycle, 32'd48);
        readReg(4'd5, rd);
        checkOutput("held write no drop", 32'(rd), 32'd0);

        // Reset while pending discards the commit.
        applyStimulus(4'd0, 16'h0002, 1, 1'b0);
        applyStimulus(4'd4, 16'h0011, 1, 1'b0);
        applyStimulus(4'd0, 16'h000A, 1, 1'b0);
        readReg(4'd5, rd);
        checkOutput("pending before reset", 32'(rd), 32'h1);
        base_count = update_count;
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset pwm_rst", 32'(pwm_rst), 32'd1);
        checkOutput("async reset pwm_en", 32'(pwm_en), 32'd0);
        checkOutput("async reset period", period, 32'd0);
        checkOutput("async reset duty", duty_cycle, 32'd0);
        cycles(1);
        rst_n = 1'b1;
        period_end = 1'b1;
        cycles(1);
        period_end = 1'b0;
        cycles(3);
        checkOutput("no pulse after reset", 32'(update_count - base_count), 32'd0);
        readReg(4'd5, rd);
        checkOutput("status after reset", 32'(rd), 32'd0);
        readReg(4'd4, rd);
        checkOutput("staging after reset", 32'(rd), 32'd0);
        readReg(4'd0, rd);
        checkOutput("ctrl after reset", 32'(rd), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
